// File: rtl/mux3_arbiter.sv
// mux3_arbiter: a three-input round-robin arbiter that registers the data of
// the winning requester and holds it until the downstream accepts it.
//
// Handshake: while valid is high, out/select hold one pending transfer. The
// transfer completes in a cycle where valid & ready; gnt is then one-hot at
// the selected requester for that same cycle. Every completion is followed
// by one IDLE cycle, so the peak rate is one transfer per two cycles. That
// IDLE bubble gives a granted requester one cycle to drop its req.
//
// Optional feature (macro ARB_LOCK_EN): this adds the lock port. If
// lock[select] is high in the completing cycle, the next arbitration goes
// straight back to the same requester when it is still requesting, and
// round-robin is bypassed. Without the macro, arbitration is pure round-robin.
module mux3_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             ready,
`ifdef ARB_LOCK_EN
  input  logic [2:0]       lock,
`endif
  output logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [2:0]       gnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Requester index that follows idx in the ring 0 -> 1 -> 2 -> 0.
  // The index 3 never occurs; it maps to 0 so that the ring stays closed.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Request bit of requester idx. An out-of-range index reads as not requesting.
  function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
    logic bit_val;
    case (idx)
      2'd0:    bit_val = r[0];
      2'd1:    bit_val = r[1];
      2'd2:    bit_val = r[2];
      default: bit_val = 1'b0;
    endcase
    return bit_val;
  endfunction

  // Data word of requester idx.
  function automatic logic [WIDTH-1:0] data_at(
    input logic [WIDTH-1:0] d0,
    input logic [WIDTH-1:0] d1,
    input logic [WIDTH-1:0] d2,
    input logic [1:0]       idx
  );
    logic [WIDTH-1:0] word;
    case (idx)
      2'd0:    word = d0;
      2'd1:    word = d1;
      default: word = d2;
    endcase
    return word;
  endfunction

  // Architectural state.
  state_t           state_reg,    state_next;
  logic [1:0]       select_reg,   select_next;
  logic [WIDTH-1:0] out_reg,      out_next;
  logic             valid_reg,    valid_next;
  logic [1:0]       last_gnt_reg, last_gnt_next;
`ifdef ARB_LOCK_EN
  logic             lock_hold_reg, lock_hold_next;
`endif

  // Round-robin candidates in priority order. Candidate 0 is the requester
  // right after last_gnt, and each later candidate is one step further round
  // the ring.
  logic [1:0] cand_idx [3];
  logic [2:0] cand_req;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    if (gi == 0) begin : g_first
      assign cand_idx[gi] = next_idx(last_gnt_reg);
    end else begin : g_rest
      assign cand_idx[gi] = next_idx(cand_idx[gi-1]);
    end
    assign cand_req[gi] = req_at(req, cand_idx[gi]);
  end

  // Pick the first requesting candidate. When nobody requests, this value
  // is not used because the FSM stays in IDLE.
  logic [1:0] rr_idx;

  always_comb begin
    rr_idx = cand_idx[2];
    if (cand_req[0]) begin
      rr_idx = cand_idx[0];
    end else if (cand_req[1]) begin
      rr_idx = cand_idx[1];
    end
  end

  // Final winner. With lock enabled, a held requester that still requests
  // overrides the round-robin result.
  logic [1:0] winner_idx;

  always_comb begin
    winner_idx = rr_idx;
`ifdef ARB_LOCK_EN
    if (lock_hold_reg && req_at(req, last_gnt_reg)) begin
      winner_idx = last_gnt_reg;
    end
`endif
  end

  // The transfer completes in this cycle.
  logic complete;
  assign complete = (state_reg == BUSY) && valid_reg && ready;

  // Next-state and register-update logic for the two-state FSM.
  always_comb begin
    state_next    = state_reg;
    select_next   = select_reg;
    out_next      = out_reg;
    valid_next    = valid_reg;
    last_gnt_next = last_gnt_reg;
`ifdef ARB_LOCK_EN
    lock_hold_next = lock_hold_reg;
`endif
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (|req) begin
          state_next  = BUSY;
          select_next = winner_idx;
          out_next    = data_at(in1, in2, in3, winner_idx);
          valid_next  = 1'b1;
`ifdef ARB_LOCK_EN
          // A hold is used by one arbitration only. It is renewed only
          // when lock is high again at the next completion.
          lock_hold_next = 1'b0;
`endif
        end
      end
      BUSY: begin
        // While ready is low, select, out and valid are held. Later changes
        // on req or on the data inputs do not affect them.
        if (complete) begin
          state_next    = IDLE;
          valid_next    = 1'b0;
          last_gnt_next = select_reg;
`ifdef ARB_LOCK_EN
          lock_hold_next = req_at(lock, select_reg);
`endif
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State registers. Reset is asynchronous, so a transfer that is pending
  // when reset is asserted is dropped without a gnt. last_gnt resets to 2 so
  // that requester 0 gets first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      select_reg   <= 2'd0;
      out_reg      <= '0;
      valid_reg    <= 1'b0;
      last_gnt_reg <= 2'd2;
    end else begin
      state_reg    <= state_next;
      select_reg   <= select_next;
      out_reg      <= out_next;
      valid_reg    <= valid_next;
      last_gnt_reg <= last_gnt_next;
    end
  end

`ifdef ARB_LOCK_EN
  // Lock-hold flag: set when the completing requester had lock high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_hold_reg <= 1'b0;
    end else begin
      lock_hold_reg <= lock_hold_next;
    end
  end
`endif

  // One-hot acknowledge decode. It is driven only in a completing cycle, so
  // gnt is 000 whenever valid is low, and also during reset.
  for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
    assign gnt[gi] = complete && (select_reg == 2'(gi));
  end

  assign select = select_reg;
  assign out    = out_reg;
  assign valid  = valid_reg;

endmodule

// File: tb/tb_mux3_arbiter.sv
// Directed, table-driven bench for mux3_arbiter. Each row gives the inputs
// for one clock cycle and the outputs expected in that cycle. Registered
// outputs show the result of earlier edges; gnt follows ready in the same
// cycle. Hand-written sequences cover reset during a grant and, when
// ARB_LOCK_EN is defined, grant locking.
module tb_mux3_arbiter;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req;
  logic [WIDTH-1:0] in1, in2, in3;
  logic             ready;
`ifdef ARB_LOCK_EN
  logic [2:0]       lock;
`endif
  logic [1:0]       select;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic [2:0]       gnt;

  int errors = 0;
  int checks = 0;

  mux3_arbiter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .ready  (ready),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .select (select),
    .out    (out),
    .valid  (valid),
    .gnt    (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic [2:0]       req;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             rdy;
    logic             ev;
    logic [1:0]       es;
    logic [WIDTH-1:0] eo;
    logic [2:0]       eg;
  } vec_t;

  vec_t vq[$];

  localparam logic [WIDTH-1:0] DA = 5'b11111;
  localparam logic [WIDTH-1:0] DB = 5'b11000;
  localparam logic [WIDTH-1:0] DC = 5'b00001;
  localparam logic [WIDTH-1:0] DD = 5'b00111;
  localparam logic [WIDTH-1:0] DZ = 5'b00000;

  task automatic add(input logic r, input logic [2:0] q,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] c, input logic rd,
                     input logic ev, input logic [1:0] es,
                     input logic [WIDTH-1:0] eo, input logic [2:0] eg);
    vec_t v;
    v.rst_n = r; v.req = q; v.d1 = a; v.d2 = b; v.d3 = c; v.rdy = rd;
    v.ev = ev; v.es = es; v.eo = eo; v.eg = eg;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // Drive one row, check the outputs away from the clock edge, then advance
  // one clock cycle.
  task automatic run(input string tag, input int id, input vec_t v);
    rst_n = v.rst_n; req = v.req; in1 = v.d1; in2 = v.d2; in3 = v.d3; ready = v.rdy;
    #1;
    $display("%s %0d: rst_n=%b req=%b ready=%b -> valid=%b select=%b out=%b gnt=%b",
             tag, id, rst_n, req, ready, valid, select, out, gnt);
    chk({tag, ".valid"},  id, {7'd0, valid},  {7'd0, v.ev});
    chk({tag, ".select"}, id, {6'd0, select}, {6'd0, v.es});
    chk({tag, ".out"},    id, {3'd0, out},    {3'd0, v.eo});
    chk({tag, ".gnt"},    id, {5'd0, gnt},    {5'd0, v.eg});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; req = '0; in1 = '0; in2 = '0; in3 = '0; ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 3'b000;
`endif

    //   rst  req     in1 in2 in3 rdy  valid sel    out  gnt
    // Reset, then a single request from in1.
    add(0, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
    add(1, 3'b001, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
    add(1, 3'b000, DA, DB, DC, 1,   1, 2'b00, DA, 3'b001);
    add(1, 3'b000, DA, DB, DC, 1,   0, 2'b00, DA, 3'b000);
    // Fairness from a fresh reset: grants 00, 01, 10, 00.
    add(0, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   1, 2'b00, DA, 3'b001);
    add(1, 3'b111, DA, DB, DC, 1,   0, 2'b00, DA, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   1, 2'b01, DB, 3'b010);
    add(1, 3'b111, DA, DB, DC, 1,   0, 2'b01, DB, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   1, 2'b10, DC, 3'b100);
    add(1, 3'b111, DA, DB, DC, 1,   0, 2'b10, DC, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   1, 2'b00, DA, 3'b001);
    // Backpressure on in2. Its data changes and its req drops while the
    // transfer is pending.
    add(1, 3'b010, DA, DB, DC, 0,   0, 2'b00, DA, 3'b000);
    add(1, 3'b010, DA, DD, DC, 0,   1, 2'b01, DB, 3'b000);
    add(1, 3'b000, DA, DD, DC, 0,   1, 2'b01, DB, 3'b000);
    add(1, 3'b000, DA, DD, DC, 0,   1, 2'b01, DB, 3'b000);
    add(1, 3'b000, DA, DD, DC, 1,   1, 2'b01, DB, 3'b010);
    add(1, 3'b000, DA, DD, DC, 1,   0, 2'b01, DB, 3'b000);
    // Reset during a pending in3 transfer, then requester 0 wins first.
    add(1, 3'b100, DA, DB, DC, 0,   0, 2'b01, DB, 3'b000);
    add(1, 3'b111, DA, DB, DC, 0,   1, 2'b10, DC, 3'b000);
    add(0, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
    add(1, 3'b111, DA, DB, DC, 1,   1, 2'b00, DA, 3'b001);

    foreach (vq[i]) run("vec", i, vq[i]);

    // Hand sequence: reset falls in the middle of a cycle in which gnt is
    // asserted. gnt and valid must drop at once, without a clock edge.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req = 3'b001; ready = 1'b0; in1 = DA;
    @(posedge clk); #1;
    ready = 1'b1; #1;
    chk("midrst.gnt_before", 0, {5'd0, gnt}, 8'b001);
    rst_n = 1'b0; #1;
    $display("midrst: rst_n=%b -> valid=%b gnt=%b select=%b", rst_n, valid, gnt, select);
    chk("midrst.gnt_after",   0, {5'd0, gnt},   8'd0);
    chk("midrst.valid_after", 0, {7'd0, valid}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 3'b010; in2 = DB;
    @(posedge clk); #1;
    $display("midrst: after release valid=%b select=%b out=%b", valid, select, out);
    chk("midrst.select", 0, {6'd0, select}, 8'b01);
    chk("midrst.out",    0, {3'd0, out},    {3'd0, DB});

`ifdef ARB_LOCK_EN
    // Hand sequence: lock[1] keeps requester 1 granted until it is cleared.
    // After that, round-robin continues with requester 2.
    begin
      vec_t lv[$];
      vq.delete();
      //   rst  req     in1 in2 in3 rdy  valid sel    out  gnt
      add(0, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
      add(1, 3'b111, DA, DB, DC, 1,   0, 2'b00, DZ, 3'b000);
      add(1, 3'b111, DA, DB, DC, 1,   1, 2'b00, DA, 3'b001);
      add(1, 3'b111, DA, DB, DC, 1,   0, 2'b00, DA, 3'b000);
      add(1, 3'b111, DA, DB, DC, 1,   1, 2'b01, DB, 3'b010);
      add(1, 3'b111, DA, DB, DC, 1,   0, 2'b01, DB, 3'b000);
      add(1, 3'b111, DA, DB, DC, 1,   1, 2'b01, DB, 3'b010);
      add(1, 3'b111, DA, DB, DC, 1,   0, 2'b01, DB, 3'b000);
      add(1, 3'b111, DA, DB, DC, 1,   1, 2'b01, DB, 3'b010);
      add(1, 3'b111, DA, DB, DC, 1,   0, 2'b01, DB, 3'b000);
      add(1, 3'b111, DA, DB, DC, 1,   1, 2'b10, DC, 3'b100);
      lv = vq;
      foreach (lv[i]) begin
        lock = (i >= 8) ? 3'b000 : 3'b010;
        run("lock", i, lv[i]);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
